// File: rtl/decode_issue.sv
// Decode/issue stage: decodes a MIPS word, reads operands from a 32x32 register
// file with writeback bypass, tracks in-flight destinations in a pending
// scoreboard and presents one registered ALU operation with valid/ready flow.
module decode_issue #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              issue_valid,
  input  logic              alu_ready,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] rs_content,
  output logic [DATA_W-1:0] rt_content,
  output logic [4:0]        shamt,
  output logic [5:0]        ALU_control,
  output logic [15:0]       immediate,
  output logic [4:0]        dest
);

  logic [5:0]        opc;
  logic [4:0]        rs_idx;
  logic [4:0]        rt_idx;
  logic [4:0]        rd_idx;
  logic [4:0]        dest_d;
  logic              wb_hit;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [31:0]       pending_q;
  logic [31:0]       pending_eff;
  logic [31:0]       pending_d;
  logic [DATA_W-1:0] regs_q [32];

  assign opc    = instr[31:26];
  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];
  assign rd_idx = instr[15:11];

  // A write to r0 is a no-op everywhere: regfile, bypass and scoreboard.
  assign wb_hit = wb_en && (wb_addr != 5'd0);

  // Destination select: R-type writes rd, branches/stores/jump write nothing.
  always_comb begin
    dest_d = rt_idx;
    case (opc)
      6'b000000:                                dest_d = rd_idx;
      6'b000100, 6'b000101, 6'b101011, 6'b000010: dest_d = 5'd0;
      default:                                  dest_d = rt_idx;
    endcase
  end

  // Scoreboard view after a same-cycle writeback clear; hazard uses this view.
  always_comb begin
    pending_eff = pending_q;
    if (wb_hit) pending_eff[wb_addr] = 1'b0;
  end

  assign hazard      = pending_eff[rs_idx] | pending_eff[rt_idx];
  assign instr_ready = (!issue_valid || alu_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  // Operand read with writeback bypass; r0 always reads zero.
  always_comb begin
    if (rs_idx == 5'd0)                  rs_val = '0;
    else if (wb_hit && wb_addr == rs_idx) rs_val = wb_data;
    else                                  rs_val = regs_q[rs_idx];
    if (rt_idx == 5'd0)                  rt_val = '0;
    else if (wb_hit && wb_addr == rt_idx) rt_val = wb_data;
    else                                  rt_val = regs_q[rt_idx];
  end

  // Next scoreboard: set applied after clear so an issue wins over a writeback.
  always_comb begin
    pending_d = pending_eff;
    if (accept && dest_d != 5'd0) pending_d[dest_d] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Register file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_hit) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Pending-destination scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Issue register: load on accept, drop valid when consumed, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      opcode      <= '0;
      rs_content  <= '0;
      rt_content  <= '0;
      shamt       <= '0;
      ALU_control <= '0;
      immediate   <= '0;
      dest        <= '0;
    end else if (accept) begin
      issue_valid <= 1'b1;
      opcode      <= opc;
      rs_content  <= rs_val;
      rt_content  <= rt_val;
      shamt       <= instr[10:6];
      ALU_control <= instr[5:0];
      immediate   <= instr[15:0];
      dest        <= dest_d;
    end else if (alu_ready) begin
      issue_valid <= 1'b0;
    end
  end

endmodule
